// File: rtl/wallace_pkg.sv
// Shared constants and elaboration-time helpers for the Wallace multiplier:
// reduction level counting and the level-to-stage map.
package wallace_pkg;

    localparam int MAX_WIDTH = 64;

    // Number of 3:2 levels needed to bring 'rows' rows down to two.
    function automatic int red_levels(input int rows);
        int r;
        int n;
        r = rows;
        n = 0;
        while (r > 2) begin
            r = 2 * (r / 3) + r % 3;
            n++;
        end
        return n;
    endfunction

    // Row count present at the input of 'level' (level 0 = partial products).
    function automatic int rows_at(input int rows, input int level);
        int r;
        r = rows;
        for (int i = 0; i < level; i++) r = 2 * (r / 3) + r % 3;
        return r;
    endfunction

    // Stage that owns a reduction level; spreads levels evenly over stages.
    function automatic int level_stage(input int level, input int levels, input int stages);
        return (level * stages) / levels;
    endfunction

    // First level owned by 'stage' (equals 'levels' past the end).
    function automatic int stage_first(input int stage, input int levels, input int stages);
        return (stage * levels + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/wallace_csa.sv
// One row of 3:2 compressors: three addend rows in, sum and carry rows out.
// The carry row is unshifted; the caller applies the one-bit weight shift.
module csa_row
    import wallace_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] s,
    output logic [W-1:0] cy
);

    assign s  = x ^ y ^ z;
    assign cy = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/wallace_pipe.sv
// Pipelined Wallace-tree multiplier with valid/ready flow control.
// Partial products (Baugh-Wooley in signed mode) are reduced by generated
// csa_row levels spread over STAGES register banks; the final carry-propagate
// add sits in the last stage, which also registers the carry-save pair.
module wallace_pipe
#(
    parameter int WIDTH  = 53,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   c0,
    output logic [2*WIDTH-1:0]   c1,
    output logic [2*WIDTH-1:0]   product,
    output logic [TAG_W-1:0]     out_tag
);
    import wallace_pkg::*;

    localparam int P  = 2 * WIDTH;
    localparam int R0 = WIDTH + 1;          // WIDTH product rows plus a constant row
    localparam int LV = red_levels(R0);

    if (WIDTH < 4 || WIDTH > MAX_WIDTH || STAGES < 1 || STAGES > 8) begin : g_bad_param
        $error("wallace_pipe: WIDTH or STAGES out of range");
    end

    logic [STAGES-1:0]            vld_pipe;
    logic [STAGES-1:0]            ld;
    logic [STAGES-1:0][TAG_W-1:0] tag_pipe;
    logic                         rdy_en;
    logic [R0-1:0][P-1:0]         pp;

    // Partial product rows; signed mode inverts the cross terms of the sign
    // row/column and adds the constant 2^WIDTH + 2^(2*WIDTH-1).
    always_comb begin
        pp = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp[i][i+j] = (a[j] & b[i]) ^ (is_signed && ((i == WIDTH-1) != (j == WIDTH-1)));
            end
        end
        if (is_signed) begin
            pp[WIDTH][WIDTH] = 1'b1;
            pp[WIDTH][P-1]   = 1'b1;
        end
    end

    // Stage k loads when empty or when its contents move on this cycle.
    always_comb begin
        ld = '0;
        ld[STAGES-1] = !vld_pipe[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) ld[k] = !vld_pipe[k] || ld[k+1];
    end

    assign in_ready  = ld[0] && rdy_en;
    assign out_valid = vld_pipe[STAGES-1];
    assign out_tag   = tag_pipe[STAGES-1];

    // Valid bits and tags shift forward; rdy_en holds in_ready low until the
    // first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
            rdy_en   <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (ld[0]) begin
                vld_pipe[0] <= in_valid && rdy_en;
                tag_pipe[0] <= in_tag;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (ld[k]) begin
                    vld_pipe[k] <= vld_pipe[k-1];
                    tag_pipe[k] <= tag_pipe[k-1];
                end
            end
        end
    end

    // Per-stage input/output rows and register banks.
    for (genvar s = 0; s < STAGES; s++) begin : g_stg
        localparam int F = stage_first(s, LV, STAGES);
        localparam int E = stage_first(s + 1, LV, STAGES);

        logic [R0-1:0][P-1:0] sin;
        logic [R0-1:0][P-1:0] sout;

        if (s == 0) begin : g_src
            assign sin = pp;
        end else begin : g_src
            assign sin = g_stg[s-1].g_bank.bank;
        end

        // A stage may own no levels when STAGES exceeds the level count.
        if (E > F) begin : g_res
            assign sout = g_lvl[E-1].dout;
        end else begin : g_res
            assign sout = sin;
        end

        if (s < STAGES - 1) begin : g_bank
            logic [R0-1:0][P-1:0] bank;

            // Intermediate rows advance with the stage valid bit.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)        bank <= '0;
                else if (ld[s]) bank <= sout;
            end
        end else begin : g_out
            logic unused_rows;
            assign unused_rows = ^sout[R0-1:2];

            // Final bank: carry-save pair plus the carry-propagate sum.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    c0      <= '0;
                    c1      <= '0;
                    product <= '0;
                end else if (ld[s]) begin
                    c0      <= sout[0];
                    c1      <= sout[1];
                    product <= sout[0] + sout[1];
                end
            end
        end
    end

    // Reduction levels: triples go through csa_row, leftovers pass through.
    for (genvar l = 0; l < LV; l++) begin : g_lvl
        localparam int RI = rows_at(R0, l);
        localparam int RO = rows_at(R0, l + 1);
        localparam int T  = RI / 3;
        localparam int ST = level_stage(l, LV, STAGES);

        logic [R0-1:0][P-1:0] din;
        logic [R0-1:0][P-1:0] dout;

        if (l == stage_first(ST, LV, STAGES)) begin : g_src
            assign din = g_stg[ST].sin;
        end else begin : g_src
            assign din = g_lvl[l-1].dout;
        end

        if (RI < R0) begin : g_sink
            logic unused_din;
            assign unused_din = ^din[R0-1:RI];
        end

        for (genvar k = 0; k < T; k++) begin : g_csa
            logic [P-1:0] sum;
            logic [P-1:0] cy;
            logic         unused_cy;

            csa_row #(.W(P)) u_csa (
                .x  (din[3*k]),
                .y  (din[3*k+1]),
                .z  (din[3*k+2]),
                .s  (sum),
                .cy (cy)
            );

            assign dout[2*k]   = sum;
            assign dout[2*k+1] = {cy[P-2:0], 1'b0};
            assign unused_cy   = cy[P-1];
        end

        for (genvar r = 2 * T; r < R0; r++) begin : g_pass
            if (r < RO) begin : g_row
                assign dout[r] = din[r+T];
            end else begin : g_row
                assign dout[r] = '0;
            end
        end
    end

endmodule

// File: tb/tb_wallace_pipe.sv
// Bench for wallace_pipe: four instances (53b/3st, 8b/3st, 16b/1st, 16b/8st)
// driven with directed vectors; in-order scoreboards check every result.
module tb_wallace_pipe;

    typedef struct {
        logic [127:0] p;
        logic [3:0]   t;
        int           c;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   done = 0;
    bit   lat0 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // u0: WIDTH=53 STAGES=3
    logic         u0_in_valid = 0, u0_in_ready, u0_sgn = 0, u0_out_valid, u0_out_ready = 1;
    logic [52:0]  u0_a = 0, u0_b = 0;
    logic [3:0]   u0_tag = 0, u0_out_tag;
    logic [105:0] u0_c0, u0_c1, u0_prod, u0_exp = 0;
    // u1: WIDTH=8 STAGES=3
    logic         u1_in_valid = 0, u1_in_ready, u1_sgn = 0, u1_out_valid;
    logic [7:0]   u1_a = 0, u1_b = 0;
    logic [3:0]   u1_tag = 0, u1_out_tag;
    logic [15:0]  u1_c0, u1_c1, u1_prod, u1_exp = 0;
    // u2 (STAGES=1) and u3 (STAGES=8), WIDTH=16, shared inputs
    logic         u2_in_valid = 0, u2_sgn = 0, u2_in_ready, u3_in_ready, u2_out_valid, u3_out_valid;
    logic [15:0]  u2_a = 0, u2_b = 0;
    logic [3:0]   u2_tag = 0, u2_out_tag, u3_out_tag;
    logic [31:0]  u2_c0, u2_c1, u2_prod, u3_c0, u3_c1, u3_prod, u2_exp = 0;

    wallace_pipe #(.WIDTH(53), .STAGES(3), .TAG_W(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(u0_in_valid), .in_ready(u0_in_ready),
        .a(u0_a), .b(u0_b), .is_signed(u0_sgn), .in_tag(u0_tag),
        .out_valid(u0_out_valid), .out_ready(u0_out_ready),
        .c0(u0_c0), .c1(u0_c1), .product(u0_prod), .out_tag(u0_out_tag));

    wallace_pipe #(.WIDTH(8), .STAGES(3), .TAG_W(4)) u1 (
        .clk(clk), .rst(rst), .in_valid(u1_in_valid), .in_ready(u1_in_ready),
        .a(u1_a), .b(u1_b), .is_signed(u1_sgn), .in_tag(u1_tag),
        .out_valid(u1_out_valid), .out_ready(1'b1),
        .c0(u1_c0), .c1(u1_c1), .product(u1_prod), .out_tag(u1_out_tag));

    wallace_pipe #(.WIDTH(16), .STAGES(1), .TAG_W(4)) u2 (
        .clk(clk), .rst(rst), .in_valid(u2_in_valid), .in_ready(u2_in_ready),
        .a(u2_a), .b(u2_b), .is_signed(u2_sgn), .in_tag(u2_tag),
        .out_valid(u2_out_valid), .out_ready(1'b1),
        .c0(u2_c0), .c1(u2_c1), .product(u2_prod), .out_tag(u2_out_tag));

    wallace_pipe #(.WIDTH(16), .STAGES(8), .TAG_W(4)) u3 (
        .clk(clk), .rst(rst), .in_valid(u2_in_valid), .in_ready(u3_in_ready),
        .a(u2_a), .b(u2_b), .is_signed(u2_sgn), .in_tag(u2_tag),
        .out_valid(u3_out_valid), .out_ready(1'b1),
        .c0(u3_c0), .c1(u3_c1), .product(u3_prod), .out_tag(u3_out_tag));

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference product of w-bit operands, modulo 2^(2w).
    function automatic logic [127:0] mdl(input logic [63:0] a, input logic [63:0] b,
                                         input logic s, input int w);
        logic [127:0] x, y;
        x = {64'b0, a};
        y = {64'b0, b};
        if (s && a[w-1]) x = x | (~128'b0 << w);
        if (s && b[w-1]) y = y | (~128'b0 << w);
        return (x * y) & ~(~128'b0 << (2 * w));
    endfunction

    ent_t         q0[$], q1[$], q2[$], q3[$];
    bit           st0 = 0;
    logic [105:0] hp0, sum0;
    logic [3:0]   ht0;
    logic [15:0]  sum1;
    logic [31:0]  sum2, sum3;

    // u0 scoreboard, with stall-stability check
    always @(negedge clk) begin : mon0
        ent_t e;
        if (rst) begin
            q0.delete();
            st0 = 0;
        end else begin
            if (st0) begin
                chk("u0_hold_prod", 128'(u0_prod), 128'(hp0));
                chk("u0_hold_tag", 128'(u0_out_tag), 128'(ht0));
                chk("u0_hold_vld", 128'(u0_out_valid), 128'd1);
            end
            st0 = u0_out_valid && !u0_out_ready;
            hp0 = u0_prod;
            ht0 = u0_out_tag;
            if (u0_out_valid && u0_out_ready) begin
                if (q0.size() == 0) chk("u0_spurious", 128'(u0_out_valid), 128'd0);
                else begin
                    e = q0.pop_front();
                    sum0 = u0_c0 + u0_c1;
                    chk("u0_prod", 128'(u0_prod), e.p);
                    chk("u0_csa", 128'(sum0), e.p);
                    chk("u0_tag", 128'(u0_out_tag), 128'(e.t));
                    if (lat0) chk("u0_lat", 128'(cyc), 128'(e.c));
                end
            end
            if (u0_in_valid && u0_in_ready) q0.push_back('{128'(u0_exp), u0_tag, cyc + 3});
        end
    end

    always @(negedge clk) begin : mon1
        ent_t e;
        if (rst) q1.delete();
        else begin
            if (u1_out_valid) begin
                if (q1.size() == 0) chk("u1_spurious", 128'(u1_out_valid), 128'd0);
                else begin
                    e = q1.pop_front();
                    sum1 = u1_c0 + u1_c1;
                    chk("u1_prod", 128'(u1_prod), e.p);
                    chk("u1_csa", 128'(sum1), e.p);
                    chk("u1_tag", 128'(u1_out_tag), 128'(e.t));
                    chk("u1_lat", 128'(cyc), 128'(e.c));
                end
            end
            if (u1_in_valid && u1_in_ready) q1.push_back('{128'(u1_exp), u1_tag, cyc + 3});
        end
    end

    always @(negedge clk) begin : mon2
        ent_t e;
        if (rst) q2.delete();
        else begin
            if (u2_out_valid) begin
                if (q2.size() == 0) chk("u2_spurious", 128'(u2_out_valid), 128'd0);
                else begin
                    e = q2.pop_front();
                    sum2 = u2_c0 + u2_c1;
                    chk("s1_prod", 128'(u2_prod), e.p);
                    chk("s1_csa", 128'(sum2), e.p);
                    chk("s1_tag", 128'(u2_out_tag), 128'(e.t));
                    chk("s1_lat", 128'(cyc), 128'(e.c));
                end
            end
            if (u2_in_valid && u2_in_ready) q2.push_back('{128'(u2_exp), u2_tag, cyc + 1});
        end
    end

    always @(negedge clk) begin : mon3
        ent_t e;
        if (rst) q3.delete();
        else begin
            if (u3_out_valid) begin
                if (q3.size() == 0) chk("u3_spurious", 128'(u3_out_valid), 128'd0);
                else begin
                    e = q3.pop_front();
                    sum3 = u3_c0 + u3_c1;
                    chk("s8_prod", 128'(u3_prod), e.p);
                    chk("s8_csa", 128'(sum3), e.p);
                    chk("s8_tag", 128'(u3_out_tag), 128'(e.t));
                    chk("s8_lat", 128'(cyc), 128'(e.c));
                end
            end
            if (u2_in_valid && u3_in_ready) q3.push_back('{128'(u2_exp), u2_tag, cyc + 8});
        end
    end

    // Each send task is entered just after a rising edge and returns just
    // after the edge on which the pair was taken.
    task automatic u0_send(input logic [52:0] a, input logic [52:0] b, input logic s,
                           input logic [3:0] t, input logic [105:0] e);
        int n = 0;
        u0_a = a; u0_b = b; u0_sgn = s; u0_tag = t; u0_exp = e; u0_in_valid = 1;
        do begin @(negedge clk); n++; end while (!u0_in_ready && n < 200);
        if (!u0_in_ready) chk("u0_accept_timeout", 128'(u0_in_ready), 128'd1);
        @(posedge clk); #1;
        u0_in_valid = 0;
    endtask

    task automatic u1_send(input logic [7:0] a, input logic [7:0] b, input logic s,
                           input logic [3:0] t, input logic [15:0] e);
        int n = 0;
        u1_a = a; u1_b = b; u1_sgn = s; u1_tag = t; u1_exp = e; u1_in_valid = 1;
        do begin @(negedge clk); n++; end while (!u1_in_ready && n < 200);
        if (!u1_in_ready) chk("u1_accept_timeout", 128'(u1_in_ready), 128'd1);
        @(posedge clk); #1;
        u1_in_valid = 0;
    endtask

    task automatic u2_send(input logic [15:0] a, input logic [15:0] b, input logic s,
                           input logic [3:0] t);
        int n = 0;
        u2_a = a; u2_b = b; u2_sgn = s; u2_tag = t; u2_in_valid = 1;
        u2_exp = 32'(mdl(64'(a), 64'(b), s, 16));
        do begin @(negedge clk); n++; end while (!(u2_in_ready && u3_in_ready) && n < 200);
        if (!(u2_in_ready && u3_in_ready)) chk("u2_accept_timeout", 128'(u3_in_ready), 128'd1);
        @(posedge clk); #1;
        u2_in_valid = 0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q0.size() + q1.size() + q2.size() + q3.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, 128'(q0.size() + q1.size() + q2.size() + q3.size()), 128'd0);
        @(posedge clk); #1;
    endtask

    logic [15:0] corner [5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    logic [52:0] ones53 = '1;

    initial begin
        // reset state
        #1;
        chk("rst_u0_vld", 128'(u0_out_valid), 128'd0);
        chk("rst_u0_rdy", 128'(u0_in_ready), 128'd0);
        chk("rst_u0_prod", 128'(u0_prod), 128'd0);
        chk("rst_u0_c0c1", 128'({u0_c0, u0_c1}), 128'd0);
        chk("rst_u0_tag", 128'(u0_out_tag), 128'd0);
        chk("rst_u3_rdy", 128'(u3_in_ready), 128'd0);
        repeat (2) @(posedge clk);
        #3 rst = 0;
        #1 chk("rel_rdy_before_edge", 128'(u0_in_ready), 128'd0);
        @(posedge clk); #1;
        chk("rel_rdy_after_edge", 128'(u0_in_ready), 128'd1);
        chk("empty_vld", 128'(u0_out_valid), 128'd0);

        // 53-bit corner products at latency 3, including a mode change
        lat0 = 1;
        u0_send(ones53, ones53, 0, 4'd1, 106'd0 - (106'd1 << 54) + 106'd1);
        u0_send(ones53, ones53, 1, 4'd2, 106'd1);
        u0_send(53'd1, ones53, 0, 4'd3, 106'(ones53));
        u0_send(53'd0, ones53, 1, 4'd4, 106'd0);
        drain("u0_dir_drain");
        lat0 = 0;

        // 8-bit signed pairs, then the same bits in unsigned mode
        u1_send(8'hFF, 8'hFF, 1, 4'd1, 16'h0001);
        u1_send(8'hFF, 8'hFF, 0, 4'd2, 16'hFE01);
        u1_send(8'h80, 8'h80, 1, 4'd3, 16'h4000);
        u1_send(8'h80, 8'h7F, 1, 4'd4, 16'hC080);
        u1_send(8'h7F, 8'h7F, 1, 4'd5, 16'h3F01);
        drain("u1_drain");

        // 16-bit corners on STAGES=1 and STAGES=8, both modes
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    u2_send(corner[i], corner[j], m[0], 4'(i * 5 + j));
        drain("u2_drain");

        // 20 random pairs with out_ready toggling every cycle
        done = 0;
        fork
            begin
                logic [52:0] ra, rb;
                logic        rs;
                for (int i = 0; i < 20; i++) begin
                    ra = 53'({$urandom, $urandom});
                    rb = 53'({$urandom, $urandom});
                    rs = 1'($urandom_range(0, 1));
                    u0_send(ra, rb, rs, 4'(i), 106'(mdl(64'(ra), 64'(rb), rs, 53)));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    u0_out_ready = ~u0_out_ready;
                end
            end
        join
        u0_out_ready = 1;
        drain("u0_stream_drain");

        // full pipe: accept and drain together for 10 cycles
        u0_out_ready = 0;
        for (int i = 0; i < 3; i++)
            u0_send(53'(i + 3), 53'(i + 5), 0, 4'(i), 106'((i + 3) * (i + 5)));
        chk("full_blocked", 128'(u0_in_ready), 128'd0);
        u0_out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            u0_a = 53'(i + 100); u0_b = 53'(i + 7); u0_sgn = 0; u0_tag = 4'(i + 3);
            u0_exp = 106'((i + 100) * (i + 7)); u0_in_valid = 1;
            @(negedge clk);
            chk("full_rdy", 128'(u0_in_ready), 128'd1);
            chk("full_vld", 128'(u0_out_valid), 128'd1);
            @(posedge clk); #1;
        end
        u0_in_valid = 0;
        drain("u0_full_drain");

        // reset with three results in flight
        u0_out_ready = 0;
        for (int i = 0; i < 3; i++)
            u0_send(53'(i + 11), 53'(i + 2), 0, 4'(i + 8), 106'((i + 11) * (i + 2)));
        rst = 1;
        #1;
        chk("midrst_vld", 128'(u0_out_valid), 128'd0);
        chk("midrst_rdy", 128'(u0_in_ready), 128'd0);
        chk("midrst_prod", 128'(u0_prod), 128'd0);
        chk("midrst_tag", 128'(u0_out_tag), 128'd0);
        @(negedge clk);
        @(posedge clk);
        #3 rst = 0;
        @(posedge clk); #1;
        chk("midrst_rdy_back", 128'(u0_in_ready), 128'd1);
        u0_out_ready = 1;
        repeat (8) @(negedge clk);
        chk("midrst_no_stale", 128'(u0_out_valid), 128'd0);
        @(posedge clk); #1;
        lat0 = 1;
        u0_send(53'd12345, 53'd678, 0, 4'd7, 106'd8369910);
        drain("u0_post_rst_drain");
        lat0 = 0;

        chk("end_empty_vld", 128'(u0_out_valid), 128'd0);
        chk("end_empty_rdy", 128'(u0_in_ready), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
